// File: rtl/cpu_bus_sequencer.sv
// Bus-cycle sequencer for the 4-bit CPU family: subcycle counter, sync/ROM/RAM
// command strobes, address/data pad multiplexing and opcode capture.
module cpu_bus_sequencer #(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned ADDR_NIBBLES  = 3,
    parameter int unsigned NUM_RAM_BANKS = 4,
    parameter int unsigned CMD_SUBCYCLE  = ADDR_NIBBLES - 1,
    localparam int unsigned PC_W = ADDR_NIBBLES * DATA_WIDTH,
    localparam int unsigned LAST = ADDR_NIBBLES + 4,
    localparam int unsigned CW   = $clog2(LAST + 1),
    localparam int unsigned BW   = (NUM_RAM_BANKS > 1) ? $clog2(NUM_RAM_BANKS) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [PC_W-1:0]          pc,
    input  logic [DATA_WIDTH-1:0]    acc,
    input  logic [DATA_WIDTH-1:0]    regval,
    input  logic                     acc_out_req,
    input  logic                     reg_out_req,
    input  logic                     ram_cmd_req,
    input  logic                     io_cmd_req,
    input  logic [BW-1:0]            ram_bank_sel,
    input  logic                     two_word,
    input  logic                     hold,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_oe,
    output logic [CW-1:0]            cycle,
    output logic                     sync,
    output logic                     rom_cmd,
    output logic [NUM_RAM_BANKS-1:0] ram_cmd_n,
    output logic [DATA_WIDTH-1:0]    opr,
    output logic [DATA_WIDTH-1:0]    opa,
    output logic                     inst_valid,
    output logic                     second_word
);

    localparam logic [CW-1:0] C_LAST = CW'(LAST);
    localparam logic [CW-1:0] C_M1   = CW'(ADDR_NIBBLES);
    localparam logic [CW-1:0] C_M2   = CW'(ADDR_NIBBLES + 1);
    localparam logic [CW-1:0] C_X1   = CW'(ADDR_NIBBLES + 2);
    localparam logic [CW-1:0] C_X2   = CW'(ADDR_NIBBLES + 3);
    localparam logic [CW-1:0] C_CMD  = CW'(CMD_SUBCYCLE);

    logic          ram_lat;
    logic          io_lat;
    logic [BW-1:0] bank_lat;
    logic          sw_fresh;
    logic          wrap;

    assign wrap = (cycle == C_LAST) && !hold;

    // Counter, command latches, opcode capture and two-word tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle       <= '0;
            opr         <= '0;
            opa         <= '0;
            inst_valid  <= 1'b0;
            second_word <= 1'b0;
            sw_fresh    <= 1'b0;
            ram_lat     <= 1'b0;
            io_lat      <= 1'b0;
            bank_lat    <= '0;
        end else begin
            if (cycle == C_LAST) begin
                if (!hold) cycle <= '0;
            end else begin
                cycle <= cycle + CW'(1);
            end

            if (cycle == '0) begin
                ram_lat  <= ram_cmd_req;
                io_lat   <= io_cmd_req;
                bank_lat <= ram_bank_sel;
            end

            if (cycle == C_M1) opr <= data_in;
            if (cycle == C_M2) opa <= data_in;
            inst_valid <= (cycle == C_M2);

            // sw_fresh lets the flag survive the wrap that ends the setting cycle
            if ((cycle == C_M2) && two_word && !second_word) begin
                second_word <= 1'b1;
                sw_fresh    <= 1'b1;
            end else if (wrap) begin
                if (sw_fresh) sw_fresh    <= 1'b0;
                else          second_word <= 1'b0;
            end
        end
    end

    // Pad multiplexing and command strobes, all forced idle during reset
    always_comb begin
        data_out  = '0;
        data_oe   = 1'b0;
        rom_cmd   = 1'b1;
        ram_cmd_n = '1;
        sync      = 1'b0;
        if (!reset) begin
            sync = wrap;
            for (int unsigned k = 0; k < ADDR_NIBBLES; k++) begin
                if (cycle == CW'(k)) begin
                    data_oe  = 1'b1;
                    data_out = pc[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (cycle >= C_X1) begin
                if (acc_out_req) begin
                    data_oe  = 1'b1;
                    data_out = acc;
                end else if (reg_out_req) begin
                    data_oe  = 1'b1;
                    data_out = regval;
                end
            end
            if ((cycle == C_CMD) || ((cycle == C_X2) && io_lat)) rom_cmd = 1'b0;
            for (int unsigned b = 0; b < NUM_RAM_BANKS; b++) begin
                if ((bank_lat == BW'(b)) &&
                    (((cycle == C_CMD) && ram_lat) || ((cycle == C_X2) && io_lat)))
                    ram_cmd_n[b] = 1'b0;
            end
        end
    end

endmodule

// File: doc/cpu_bus_sequencer.md
Name: cpu_bus_sequencer

Overview:
- Parametrised bus-cycle sequencer for the 4-bit CPU family.
- Owns the instruction-cycle subcycle counter, the sync / ROM / RAM command strobes, the address/data pad multiplexing and opcode capture.
- Generalises the fixed 8-subcycle, 12-bit-address, 4-bank bus to configurable data width, address nibble count and bank count.
- Adds hold (wait-state) stretching, a second-subcycle I/O command strobe and two-word instruction tracking.
- Sits between cpu_control/datapath/pc_stack and the top-level tristate pads; the top builds the inout from data_out/data_oe.

Parameters:
- DATA_WIDTH, 4, width of bus word and of acc/regval/opr/opa.
- ADDR_NIBBLES, 3, address subcycles per instruction cycle; pc width = ADDR_NIBBLES*DATA_WIDTH.
- NUM_RAM_BANKS, 4, number of active-low RAM command lines.
- CMD_SUBCYCLE, ADDR_NIBBLES-1, subcycle in which the address command strobe fires.
- Derived: LAST = ADDR_NIBBLES+4; CW = clog2(LAST+1); BW = max(1, clog2(NUM_RAM_BANKS)).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- pc  in  ADDR_NIBBLES*DATA_WIDTH  fetch address.
- acc  in  DATA_WIDTH  accumulator value for output.
- regval  in  DATA_WIDTH  register value for output.
- acc_out_req  in  1  drive acc during execute subcycles.
- reg_out_req  in  1  drive regval during execute subcycles.
- ram_cmd_req  in  1  assert a RAM command this instruction cycle.
- io_cmd_req  in  1  assert the I/O command strobe in X2.
- ram_bank_sel  in  BW  RAM bank index.
- two_word  in  1  decoded instruction needs a second word; valid during M2.
- hold  in  1  stretch the current cycle in its last subcycle.
- data_in  in  DATA_WIDTH  pad input.
- data_out  out  DATA_WIDTH  pad output value.
- data_oe  out  1  pad output enable.
- cycle  out  CW  current subcycle.
- sync  out  1  marks the last subcycle before A1.
- rom_cmd  out  1  active-low ROM command.
- ram_cmd_n  out  NUM_RAM_BANKS  active-low, one-hot RAM commands.
- opr  out  DATA_WIDTH  captured upper opcode nibble.
- opa  out  DATA_WIDTH  captured lower opcode nibble.
- inst_valid  out  1  one-clock pulse when opr/opa are fresh.
- second_word  out  1  current cycle fetches operand word.

Behaviour:
- Subcycle map:
  - 0..ADDR_NIBBLES-1: A phases.
  - ADDR_NIBBLES: M1.
  - ADDR_NIBBLES+1: M2.
  - ADDR_NIBBLES+2 .. LAST: X1, X2, X3.
- Counter: increments each clock and wraps LAST->0. In LAST with hold=1 it stays at LAST. Hold is ignored in all other subcycles.
- sync = (cycle==LAST) & ~hold, combinational.
- A phase k: data_oe=1, data_out=pc[k*DATA_WIDTH +: DATA_WIDTH], low nibble first.
- M1 and M2: data_oe=0. data_in is registered into opr at the end of M1 and into opa at the end of M2.
- inst_valid: high for the single clock after M2 (i.e. during X1).
- second_word: set at end of M2 if two_word=1 and second_word=0. Cleared at the LAST->0 wrap of the following cycle. A two_word seen while second_word=1 is ignored.
- X phases: priority is acc_out_req, then reg_out_req. The selected value is driven with data_oe=1; with neither request, data_oe=0. Requests are sampled combinationally each X subcycle.
- Command latching: ram_cmd_req, io_cmd_req and ram_bank_sel are registered at the end of subcycle 0 and held for the rest of the cycle.
- rom_cmd: low in CMD_SUBCYCLE every cycle, and also in X2 when io_cmd_req is latched; otherwise high.
- ram_cmd_n[b]:
  - Low in CMD_SUBCYCLE when ram_cmd_req is latched and the latched bank==b.
  - Low in X2 when io_cmd_req is latched and the latched bank==b.
  - Otherwise high.
  - A bank index >= NUM_RAM_BANKS asserts no line.
- Held LAST: X3 data drive continues and all command lines stay high.
- Reset (any subcycle):
  - Next cycle=0; opr=opa=0; inst_valid=0; second_word=0; latched requests cleared.
  - While reset=1: data_oe=0, rom_cmd=1, ram_cmd_n all 1, sync=0.
  - First clock after reset deasserts starts A1 (cycle 0).
- Simultaneous hold and reset: reset wins.

Test Plan:
- Defaults, pc=0xABC, no requests, 2 cycles:
  - cycle runs 0..7,0..7.
  - data_out C,B,A with oe=1 in subcycles 0-2.
  - rom_cmd low only in subcycle 2.
  - sync high only in subcycle 7.
  - ram_cmd_n=4'hF throughout.
- data_in=0x2 in M1 and 0x5 in M2:
  - opr=2, opa=5.
  - inst_valid high exactly in subcycle 5.
- ram_cmd_req=1, ram_bank_sel=2, io_cmd_req=1, acc=0x9, acc_out_req=1, reg_out_req=1:
  - ram_cmd_n=4'b1011 in subcycles 2 and 6.
  - rom_cmd low in subcycles 2 and 6.
  - data_out=9 with oe=1 in subcycles 5-7.
- hold=1 for 3 clocks entering subcycle 7:
  - cycle stays 7 for 4 clocks.
  - sync low for the first 3, high on the 4th, then cycle=0.
- two_word=1 at M2 in two successive cycles:
  - second_word high through the whole next cycle only.
  - The second two_word is ignored.
  - second_word low again after the wrap.
- Reset asserted at subcycle 4 with ram_cmd_req latched:
  - Next cycle=0, outputs at reset values, ram_cmd_n=4'hF.
- ADDR_NIBBLES=4, NUM_RAM_BANKS=8, pc=0x1234:
  - Counter wraps at 8 (9 subcycles).
  - Address nibbles 4,3,2,1.
  - rom_cmd low in subcycle 3.
  - bank 7 drives ram_cmd_n[7] low.
